// File: rtl/rf_writeback_pkg.sv
// rtl/rf_writeback_pkg.sv - shared widths, register-zero index and writeback source encoding
package rf_writeback_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ZERO       = 0;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    function automatic int nregs(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// rtl/wb_rr_arb.sv - two-request round-robin arbiter with one-hot grant
module wb_rr_arb
    import rf_writeback_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e ptr;
    wb_src_e ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SRC_EXU;
        end else begin
            ptr <= ptr_next;
        end
    end

    // The pointer only moves when both sources competed, so a lone
    // requester never costs the other one its turn.
    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (ptr == SRC_EXU) begin
                    gnt      = 2'b01;
                    ptr_next = SRC_LSU;
                end else begin
                    gnt      = 2'b10;
                    ptr_next = SRC_EXU;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - regfile write port arbitration and busy scoreboard
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  rsv_ready,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2
);

    localparam int                    NREGS     = nregs(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [1:0]            gnt;
    logic [NREGS-1:0]      busy;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_wr;

    wb_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_valid, exu_valid}),
        .gnt (gnt)
    );

    assign exu_ready = gnt[0];
    assign lsu_ready = gnt[1];
    assign rsv_ready = (rsv_addr == ADDR_ZERO) || !busy[rsv_addr];

    assign chk_busy1 = (chk_addr1 != ADDR_ZERO) && busy[chk_addr1];
    assign chk_busy2 = (chk_addr2 != ADDR_ZERO) && busy[chk_addr2];

    always_comb begin
        sel_rd   = exu_rd;
        sel_data = exu_data;
        if (gnt[1]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // An x0 result still consumes its grant but never reaches the regfile.
    assign sel_wr = (gnt != 2'b00) && (sel_rd != ADDR_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= sel_wr;
            if (sel_wr) begin
                waddr <= sel_rd;
                wdata <= sel_data;
            end
        end
    end

    // Clear wins over set; the regfile write lands on this same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wen && (waddr == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b0;
                end else if (rsv_valid && rsv_ready && (rsv_addr == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b1;
                end
            end
            busy[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wen && (waddr != ADDR_ZERO)) begin
            assert (busy[waddr]);
        end
    end

endmodule
